tdm_demux_1x8: RTL and testbench
================================

# tdm_demux_1x8

Time-division 1-to-8 demultiplexer: takes a serial stream carrying one bit per time slot, steers each slot to its channel, and presents a complete 8-channel frame on registered outputs. It is the receive-side counterpart of the team's 8-to-1 mux. That mux serialises eight lines onto one wire under a 3-bit select. This block recovers them, tracking the select value internally from a frame-sync marker. Sync loss and (optionally) parity faults are flagged.

## Interface
- N_CH, 8, number of channels; power of two, ≥2; SEL_W = clog2(N_CH)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- din  in  1  serial slot data
- in_valid  in  1  din/sync qualify this cycle; low = gap, nothing advances
- sync  in  1  marks the accepted bit as slot 0; ignored when in_valid low
- ch  out  N_CH  last good frame; ch[i] = slot i bit
- frame_valid  out  1  one-cycle pulse: ch just updated
- sel  out  SEL_W  slot index the next accepted bit will occupy
- locked  out  1  high while in RECV
- sync_err  out  1  one-cycle pulse on sync misalignment
- par_err  out  1  one-cycle pulse on parity failure; tied 0 without TDM_DEMUX_PARITY_EN

## Operation
- Reset values: ch=0, frame_valid=0, sync_err=0, par_err=0, sel=0, locked=0, state HUNT, shadow register cleared.
- HUNT: accepted bits without sync are discarded. On in_valid&sync: shadow[0]=din, sel=1, go RECV.
- RECV: each accepted bit writes shadow[sel] and increments sel.
- Last data slot (sel=N_CH-1) accepted, parity disabled: ch ← shadow with this bit, frame_valid pulses, sel wraps to 0, stay RECV.
- sel=0 in RECV, bit accepted with sync: normal frame start, as in HUNT.
- sel=0 in RECV, bit accepted without sync: sync_err pulses, bit discarded, go HUNT.
- Sync accepted at sel≠0: sync_err pulses and the partial frame is dropped. The bit becomes slot 0, sel=1, stay RECV (immediate resync).
- Sync on the last data slot is a misalignment. It takes the resync path and no frame is published.
- ch holds its value between good frames. Error pulses never modify ch.
- Steering uses the combinational 1-to-8 decoder on sel to generate the shadow-register write enables.

## Timing
- Latency: frame_valid and the new ch appear on the clock edge that accepts the last slot, so they are visible the following cycle.
- Back-to-back frames with no gaps give one frame_valid every N_CH cycles (N_CH+1 with parity).
- in_valid may drop at any slot. State, sel and shadow hold unchanged.
- rst has priority over all inputs, including mid-frame: the partial frame is lost, ch clears, and the block returns to HUNT.
- Pulses (frame_valid, sync_err, par_err) are exactly one cycle wide and mutually exclusive.

## Configuration
- TDM_DEMUX_PARITY_EN defined: each frame carries one extra slot (index N_CH, sel width grows by one bit) with even parity over the N_CH data bits plus the parity bit.
  - Pass: ch updates and frame_valid pulses after the parity slot.
  - Fail: par_err pulses, ch is unchanged, sel wraps to 0, state stays RECV.
  - Sync on the parity slot: sync_err, resync path.
- Not defined: no parity slot, par_err is constant 0, frame length is N_CH.

## Structure
- Package tdm_demux_pkg: state typedef (HUNT, RECV), N_CH default, SEL_W, frame-length constant (N_CH or N_CH+1 per macro).
- Sub-module demux_1x8: combinational select-to-one-hot decoder with enable (sel, en → N_CH write strobes), the inverse of the 8-to-1 mux.
- Top holds the FSM, slot counter, shadow register, output registers, and parity check.

## Test plan
- Reset, then sync+0xA5 slots (1,0,1,0,0,1,0,1), continuous → ch=0xA5, frame_valid one cycle after slot 7, sel=0, locked=1.
- Same frame with in_valid low for 3 cycles after slot 3 → ch=0xA5, frame_valid delayed 3 cycles, no errors.
- Frame 0x3C, then next frame's slot 0 without sync → sync_err pulse, locked=0, ch stays 0x3C.
- Sync reasserted at slot 5 of a frame, then 8 clean slots of 0xF0 → sync_err at slot 5, ch=0xF0, exactly one frame_valid.
- rst asserted at slot 4, then a clean 0x81 frame → ch=0 after reset, then 0x81, no stale bits.
- With TDM_DEMUX_PARITY_EN: 0xA5 with parity 0 → ch=0xA5. Then 0x07 with parity 0 → par_err, ch stays 0xA5, no frame_valid.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared constants and state type for the TDM 1-to-8 demux
// Frame length and slot-counter width depend on TDM_DEMUX_PARITY_EN.
package tdm_demux_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = $clog2(N_CH);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = N_CH + 1;
  localparam int CNT_W     = SEL_W + 1;
`else
  localparam int FRAME_LEN = N_CH;
  localparam int CNT_W     = SEL_W;
`endif

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux_1x8_decoder.sv
// rtl/tdm_demux_1x8_decoder.sv - select-to-one-hot decoder with enable (module demux_1x8)
// Produces the shadow-register write strobes; the inverse of the 8-to-1 mux select.
module demux_1x8 #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N_CH-1:0]  strobe
);

  always_comb begin
    strobe = '0;
    for (int i = 0; i < N_CH; i++) begin
      strobe[i] = en && (sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/tdm_demux_1x8.sv
// rtl/tdm_demux_1x8.sv - TDM 1-to-8 demultiplexer with sync tracking and frame publish
// Optional even-parity slot enabled by TDM_DEMUX_PARITY_EN.
module tdm_demux_1x8
  import tdm_demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             in_valid,
  input  logic             sync,
  output logic [N_CH-1:0]  ch,
  output logic             frame_valid,
  output logic [CNT_W-1:0] sel,
  output logic             locked,
  output logic             sync_err,
  output logic             par_err
);

  localparam logic [CNT_W-1:0] LAST_SEL = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0]  shadow_q, shadow_d, shadow_base;
  logic [N_CH-1:0]  ch_q, ch_d;
  logic             fv_q, fv_d;
  logic             se_q, se_d;
  logic             pe_q, pe_d;

  logic [CNT_W-1:0] wr_sel;
  logic             wr_en, wr_clear, dec_en;
  logic [N_CH-1:0]  strobe;

`ifdef TDM_DEMUX_PARITY_EN
  // The parity slot has no shadow bit, so its index never produces a strobe.
  assign dec_en = wr_en & ~wr_sel[SEL_W];
`else
  assign dec_en = wr_en;
`endif

  demux_1x8 #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_decoder (
    .sel    (wr_sel[SEL_W-1:0]),
    .en     (dec_en),
    .strobe (strobe)
  );

  assign shadow_base = wr_clear ? '0 : shadow_q;
  assign shadow_d    = (shadow_base & ~strobe) | (strobe & {N_CH{din}});

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ch_d     = ch_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;
    pe_d     = 1'b0;
    wr_sel   = sel_q;
    wr_en    = 1'b0;
    wr_clear = 1'b0;

    if (in_valid) begin
      if (sync) begin
        // Any accepted sync starts a fresh frame; outside slot 0 it is also a misalignment.
        se_d     = (state_q == RECV) && (sel_q != '0);
        wr_sel   = '0;
        wr_en    = 1'b1;
        wr_clear = 1'b1;
        sel_d    = CNT_W'(1);
        state_d  = RECV;
      end else if (state_q == RECV) begin
        if (sel_q == '0) begin
          se_d    = 1'b1;
          state_d = HUNT;
        end else begin
          wr_en = 1'b1;
          if (sel_q == LAST_SEL) begin
            sel_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
            if (^{shadow_q, din} == 1'b0) begin
              ch_d = shadow_q;
              fv_d = 1'b1;
            end else begin
              pe_d = 1'b1;
            end
`else
            ch_d = shadow_d;
            fv_d = 1'b1;
`endif
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      sel_q    <= '0;
      shadow_q <= '0;
      ch_q     <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      ch_q     <= ch_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
      pe_q     <= pe_d;
    end
  end

  assign ch          = ch_q;
  assign frame_valid = fv_q;
  assign sel         = sel_q;
  assign locked      = (state_q == RECV);
  assign sync_err    = se_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err     = pe_q;
`else
  assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// tb/tb_tdm_demux_1x8.sv - directed self-checking bench for tdm_demux_1x8
// Parity-slot steps run only when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_1x8;
  import tdm_demux_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             in_valid = 1'b0;
  logic             sync = 1'b0;
  logic [N_CH-1:0]  ch;
  logic             frame_valid;
  logic [CNT_W-1:0] sel;
  logic             locked;
  logic             sync_err;
  logic             par_err;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0;
  int se_cnt = 0;
  int pe_cnt = 0;

  always #5 clk = ~clk;

  tdm_demux_1x8 dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .in_valid    (in_valid),
    .sync        (sync),
    .ch          (ch),
    .frame_valid (frame_valid),
    .sel         (sel),
    .locked      (locked),
    .sync_err    (sync_err),
    .par_err     (par_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step(input bit v, input bit s, input bit d);
    in_valid = v;
    sync     = s;
    din      = d;
    @(posedge clk);
    #1;
    fv_cnt += int'(frame_valid);
    se_cnt += int'(sync_err);
    pe_cnt += int'(par_err);
  endtask

  function automatic bit slot_bit(input logic [N_CH-1:0] data, input int i);
    logic [N_CH-1:0] d;
    d = data;
    if (i < N_CH) return d[i];
    return ^d;
  endfunction

  task automatic slots(input logic [N_CH-1:0] data, input int from, input int to, input bit sync_first);
    for (int i = from; i <= to; i++) begin
      step(1'b1, sync_first && (i == from), slot_bit(data, i));
    end
  endtask

  task automatic clr_counts();
    fv_cnt = 0;
    se_cnt = 0;
    pe_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_ch", ch, 0);
    chk("reset_fv", frame_valid, 0);
    chk("reset_sel", sel, 0);
    chk("reset_locked", locked, 0);
    chk("reset_sync_err", sync_err, 0);
    chk("reset_par_err", par_err, 0);
    rst = 1'b0;

    // Bits without sync are dropped while hunting.
    clr_counts();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("hunt_locked", locked, 0);
    chk("hunt_sel", sel, 0);
    chk("hunt_no_err", se_cnt, 0);

    // Continuous 0xA5 frame.
    clr_counts();
    slots(8'hA5, 0, 0, 1'b1);
    chk("a5_sel_after_slot0", sel, 1);
    chk("a5_locked", locked, 1);
    slots(8'hA5, 1, FRAME_LEN - 1, 1'b0);
    chk("a5_fv", frame_valid, 1);
    chk("a5_ch", ch, 8'hA5);
    chk("a5_sel_wrap", sel, 0);
    chk("a5_fv_count", fv_cnt, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("a5_fv_one_cycle", frame_valid, 0);
    chk("a5_ch_hold", ch, 8'hA5);

    // 0xA5 with a 3-cycle gap after slot 3.
    clr_counts();
    slots(8'hA5, 0, 3, 1'b1);
    for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0);
    chk("gap_sel_hold", sel, 4);
    chk("gap_no_fv", fv_cnt, 0);
    slots(8'hA5, 4, FRAME_LEN - 1, 1'b0);
    chk("gap_fv", frame_valid, 1);
    chk("gap_ch", ch, 8'hA5);
    chk("gap_no_err", se_cnt + pe_cnt, 0);

    // 0x3C then a slot 0 without sync.
    slots(8'h3C, 0, FRAME_LEN - 1, 1'b1);
    chk("3c_ch", ch, 8'h3C);
    step(1'b1, 1'b0, 1'b1);
    chk("loss_sync_err", sync_err, 1);
    chk("loss_locked", locked, 0);
    chk("loss_sel", sel, 0);
    chk("loss_ch_hold", ch, 8'h3C);
    step(1'b0, 1'b0, 1'b0);
    chk("loss_pulse_width", sync_err, 0);

    // Sync at slot 5 resyncs onto a clean 0xF0 frame.
    clr_counts();
    slots(8'h00, 0, 4, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("resync_sync_err", sync_err, 1);
    chk("resync_sel", sel, 1);
    chk("resync_locked", locked, 1);
    chk("resync_ch_hold", ch, 8'h3C);
    slots(8'hF0, 1, FRAME_LEN - 1, 1'b0);
    chk("resync_ch", ch, 8'hF0);
    chk("resync_fv_count", fv_cnt, 1);
    chk("resync_se_count", se_cnt, 1);

    // Sync on the last slot: misalignment, nothing published.
    clr_counts();
    slots(8'h55, 0, FRAME_LEN - 2, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("lastsync_err", sync_err, 1);
    chk("lastsync_no_fv", fv_cnt, 0);
    chk("lastsync_sel", sel, 1);
    chk("lastsync_ch_hold", ch, 8'hF0);
    slots(8'h33, 1, FRAME_LEN - 1, 1'b0);
    chk("lastsync_next_ch", ch, 8'h33);

    // Reset mid-frame, then a clean 0x81.
    slots(8'hFF, 0, 3, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    chk("midrst_ch", ch, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_sel", sel, 0);
    slots(8'h81, 0, FRAME_LEN - 1, 1'b1);
    chk("midrst_81_ch", ch, 8'h81);
    chk("midrst_81_fv", frame_valid, 1);

`ifdef TDM_DEMUX_PARITY_EN
    slots(8'hA5, 0, FRAME_LEN - 1, 1'b1);
    chk("par_a5_ch", ch, 8'hA5);
    clr_counts();
    slots(8'h07, 0, N_CH - 1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("par_err_pulse", par_err, 1);
    chk("par_ch_hold", ch, 8'hA5);
    chk("par_no_fv", fv_cnt, 0);
    chk("par_sel_wrap", sel, 0);
    chk("par_locked", locked, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
